btn_scan_arbiter: RTL and testbench
===================================

Name: btn_scan_arbiter

Overview:
- Debounces N raw push-buttons using one shared settle counter instead of one counter per button.
- A round-robin scheduler grants the counter to one button at a time.
- Confirmed rising edges become 8-bit key codes in a small FIFO.
- The FIFO feeds the LC-3 keyboard interface: kb_ready drives KBSR[15], kb_data drives KBDR, kb_ack is the KBDR read strobe.

Parameters:
- N_BTN, 4, number of button inputs (1..8).
- TIMES, 16'hFFFF, settle time in clk cycles; legal range 1..16'hFFFF.
- KEY_BASE, 8'h30, key code for button 0; button g emits KEY_BASE+g, mod 256.
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- btn_in  input  N_BTN  raw, asynchronous button levels.
- lvl  output  N_BTN  debounced stable level per button (registered).
- busy  output  1  high while the settle counter is granted (state SETTLE).
- kb_ready  output  1  FIFO not empty.
- kb_data  output  8  FIFO head code; 8'h00 when empty.
- kb_ack  input  1  one-cycle pop strobe from the LC-3 KBDR read.
- ovf  output  1  sticky; set when an event is dropped because the FIFO is full.

Behaviour:
- Reset values: lvl=0, busy=0, kb_ready=0, kb_data=0, ovf=0, state=IDLE, rr=0, cnt=0, sync flops=0, FIFO pointers=0.
- Synchroniser: btn_in passes through 2 flops per bit to give s[]. s lags btn_in by 2 edges.
- Pending set: pend[i] = (s[i] != lvl[i]).
- IDLE: if pend is non-zero:
  - grant g = first set index scanning rr, rr+1, ..., N_BTN-1, 0, ... (wrapping);
  - on the next edge: cnt<=0, state<=SETTLE, busy=1.
  - If pend is zero, stay in IDLE.
- SETTLE, evaluated each edge, priority order:
  - (a) if s[g]==lvl[g] (bounce back): state<=IDLE, lvl unchanged, rr<=(g+1) mod N_BTN.
  - (b) else if cnt==TIMES-1: lvl[g]<=s[g], rr<=(g+1) mod N_BTN, state<=IDLE. If s[g]==1, push KEY_BASE+g.
  - (c) else cnt<=cnt+1.
  - Net effect: lvl[g] changes exactly TIMES edges after the IDLE grant edge, provided s[g] stays constant.
  - Changes on other buttons during SETTLE are ignored until that button is granted later.
- Latency: a clean raw edge on an idle system reaches lvl after 2 (sync) + 1 (grant) + TIMES edges. The FIFO push happens on the same edge; kb_ready rises the same cycle lvl does.
- Falling edges update lvl but push nothing.
- Round-robin fairness: a continuously bouncing button cannot starve others, because rr always advances past g.
- FIFO:
  - Push and pop take effect on the same edge.
  - Pop occurs only when kb_ack=1 and not empty; kb_ack while empty is ignored.
  - Full with simultaneous push and pop: both succeed, no overflow.
  - Full with push and no pop: the new code is dropped and ovf<=1.
  - ovf clears only on reset.
  - kb_data is read combinationally from the registered head entry.
- Reset asserted mid-SETTLE: counter and grant are lost; lvl returns to 0. After release, any button held high re-debounces from scratch and emits a fresh event.

Decomposition:
- Shared package lc3_btn_pkg holds:
  - state encoding IDLE=1'b0, SETTLE=1'b1;
  - default constants N_BTN, TIMES, KEY_BASE;
  - the 8-bit key-code type.
- One sub-module: btn_evt_fifo.
  - Parameters: DEPTH, WIDTH=8.
  - Ports: clk, reset, push, din, pop, dout, empty, full.
  - Same async active-low reset.

Test Plan (TIMES=4, N_BTN=4, KEY_BASE=8'h30):
- Clean press: btn_in[2] 0->1 held -> busy high for 4 cycles, then lvl=4'b0100, kb_ready=1, kb_data=8'h32. Press-to-lvl is 7 edges.
- Bounce: btn_in[1] high for 2 cycles then low -> busy pulse, lvl stays 0, no push, rr=2.
- Simultaneous: btn_in[0] and btn_in[3] rise together, rr=0 -> button 0 settles first. Events arrive 8'h30 then 8'h33. lvl[3] updates 4+1 edges after lvl[0].
- Release: after the press case, btn_in[2] 1->0 -> lvl[2]=0 after TIMES, no new FIFO entry, kb_data still 8'h32 until kb_ack.
- Overflow: 5 presses without kb_ack -> FIFO holds the first 4 codes, ovf=1. Then 4 kb_ack pulses -> codes in order, kb_ready=0, ovf stays 1. A kb_ack while empty has no effect.
- Async reset: assert reset mid-SETTLE with btn_in[1] held high -> outputs 0 immediately. After release, lvl[1]=1 and code 8'h31 are pushed after 2+1+4 edges.

Source files
------------

// File: rtl/lc3_btn_pkg.sv
// Shared types and default constants for the LC-3 button scanner.
package lc3_btn_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_t;

   typedef logic [7:0] key_code_t;

   localparam int        N_BTN_DEFAULT    = 4;
   localparam logic [15:0] TIMES_DEFAULT  = 16'hFFFF;
   localparam key_code_t KEY_BASE_DEFAULT = 8'h30;

endpackage

// File: rtl/btn_scan_arbiter_if.sv
// LC-3 keyboard port: status bit, data register and read strobe.
interface btn_scan_arbiter_if;
   import lc3_btn_pkg::*;

   logic      kb_ready;
   key_code_t kb_data;
   logic      kb_ack;

   // Key source side (the scanner).
   modport master (output kb_ready, output kb_data, input kb_ack);
   // Consumer side (the LC-3 KBSR/KBDR logic).
   modport slave  (input kb_ready, input kb_data, output kb_ack);

endinterface

// File: rtl/btn_evt_fifo.sv
// Small event FIFO; wrap-bit pointers distinguish full from empty.
// A push while full is accepted only if a pop happens on the same edge.
module btn_evt_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW:0]      wr_ptr_r;
   logic [AW:0]      rd_ptr_r;
   logic             pop_ok_s;
   logic             push_ok_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                      (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign pop_ok_s  = pop && !empty;
   assign push_ok_s = push && (!full || pop_ok_s);
   assign dout      = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r[AW-1:0]];

   // Storage and pointer update; push and pop share the same edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r <= {(AW+1){1'b0}};
         rd_ptr_r <= {(AW+1){1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
            wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/btn_scan_arbiter.sv
// Debounces N buttons with one shared settle counter granted round-robin;
// confirmed presses are queued as key codes for the LC-3 keyboard port.
module btn_scan_arbiter
   import lc3_btn_pkg::*;
#(
   parameter int          N_BTN      = N_BTN_DEFAULT,
   parameter logic [15:0] TIMES      = TIMES_DEFAULT,
   parameter key_code_t   KEY_BASE   = KEY_BASE_DEFAULT,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BTN-1:0]     btn_in,
   output logic [N_BTN-1:0]     lvl,
   output logic                 busy,
   output logic                 ovf,
   btn_scan_arbiter_if.master   kb
);

   localparam int RR_W = (N_BTN > 1) ? $clog2(N_BTN) : 1;

   logic [N_BTN-1:0] sync1_r;
   logic [N_BTN-1:0] s_r;
   logic [N_BTN-1:0] lvl_r;
   logic [N_BTN-1:0] lvl_s;
   logic [N_BTN-1:0] pend_s;
   state_t           state_r;
   state_t           state_s;
   logic [RR_W-1:0]  rr_r;
   logic [RR_W-1:0]  rr_s;
   logic [RR_W-1:0]  g_r;
   logic [RR_W-1:0]  g_s;
   logic [RR_W-1:0]  grant_s;
   logic [RR_W-1:0]  idx_s;
   logic [RR_W-1:0]  rr_next_s;
   logic             found_s;
   logic [15:0]      cnt_r;
   logic [15:0]      cnt_s;
   logic             push_s;
   key_code_t        code_s;
   logic             ovf_r;
   logic             fifo_empty_s;
   logic             fifo_full_s;

   assign pend_s    = s_r ^ lvl_r;
   assign rr_next_s = (g_r == RR_W'(N_BTN - 1)) ? {RR_W{1'b0}} : g_r + RR_W'(1);
   assign code_s    = KEY_BASE + key_code_t'(g_r);
   assign lvl       = lvl_r;
   assign busy      = (state_r == SETTLE);
   assign ovf       = ovf_r;
   assign kb.kb_ready = !fifo_empty_s;

   // Two-flop synchroniser for the raw button levels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= {N_BTN{1'b0}};
         s_r     <= {N_BTN{1'b0}};
      end else begin
         sync1_r <= btn_in;
         s_r     <= sync1_r;
      end
   end

   // Find the first pending button starting at rr, wrapping around.
   always_comb begin
      grant_s = rr_r;
      found_s = 1'b0;
      idx_s   = rr_r;
      for (int k = 0; k < N_BTN; k++) begin
         if (int'(rr_r) + k >= N_BTN) begin
            idx_s = RR_W'(int'(rr_r) + k - N_BTN);
         end else begin
            idx_s = RR_W'(int'(rr_r) + k);
         end
         if (!found_s && pend_s[idx_s]) begin
            grant_s = idx_s;
            found_s = 1'b1;
         end else begin
            grant_s = grant_s;
            found_s = found_s;
         end
      end
   end

   // Scheduler/settle FSM: next state, counter, level update and push.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      rr_s    = rr_r;
      g_s     = g_r;
      lvl_s   = lvl_r;
      push_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (|pend_s) begin
               state_s = SETTLE;
               cnt_s   = 16'h0000;
               g_s     = grant_s;
            end else begin
               state_s = IDLE;
            end
         end
         SETTLE: begin
            if (s_r[g_r] == lvl_r[g_r]) begin
               state_s = IDLE;
               rr_s    = rr_next_s;
            end else if (cnt_r == TIMES - 16'd1) begin
               lvl_s[g_r] = s_r[g_r];
               rr_s       = rr_next_s;
               state_s    = IDLE;
               push_s     = s_r[g_r];
            end else begin
               cnt_s = cnt_r + 16'd1;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // FSM and scheduler registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= IDLE;
         cnt_r   <= 16'h0000;
         rr_r    <= {RR_W{1'b0}};
         g_r     <= {RR_W{1'b0}};
         lvl_r   <= {N_BTN{1'b0}};
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         rr_r    <= rr_s;
         g_r     <= g_s;
         lvl_r   <= lvl_s;
      end
   end

   // Sticky overflow: a push that the full FIFO cannot take this edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_r <= 1'b0;
      end else if (push_s && fifo_full_s && !(kb.kb_ack && !fifo_empty_s)) begin
         ovf_r <= 1'b1;
      end else begin
         ovf_r <= ovf_r;
      end
   end

   btn_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_s),
      .din   (code_s),
      .pop   (kb.kb_ack),
      .dout  (kb.kb_data),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

endmodule

// File: tb/tb_btn_scan_arbiter.sv
// Directed bench for btn_scan_arbiter with TIMES=4, N_BTN=4, KEY_BASE=8'h30.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_btn_scan_arbiter;

   logic       clk;
   logic       reset;
   logic [3:0] btn_in;
   logic [3:0] lvl;
   logic       busy;
   logic       ovf;
   int         checks;
   int         failures;

   btn_scan_arbiter_if kb_if ();

   btn_scan_arbiter #(
      .N_BTN      (4),
      .TIMES      (16'd4),
      .KEY_BASE   (8'h30),
      .FIFO_DEPTH (4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .btn_in (btn_in),
      .lvl    (lvl),
      .busy   (busy),
      .ovf    (ovf),
      .kb     (kb_if)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse();
      kb_if.kb_ack = 1'b1;
      step(1);
      kb_if.kb_ack = 1'b0;
   endtask

   // Press button idx, hold until debounced, release and wait out the release.
   task automatic press_release(input int idx);
      btn_in[idx] = 1'b1;
      step(7);
      btn_in[idx] = 1'b0;
      step(7);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      reset         = 1'b0;
      btn_in        = 4'b0000;
      kb_if.kb_ack  = 1'b0;
      step(2);
      chk("rst_lvl",   {28'h0, lvl}, 32'h0);
      chk("rst_busy",  {31'h0, busy}, 32'h0);
      chk("rst_ready", {31'h0, kb_if.kb_ready}, 32'h0);
      chk("rst_data",  {24'h0, kb_if.kb_data}, 32'h0);
      chk("rst_ovf",   {31'h0, ovf}, 32'h0);
      reset = 1'b1;
      step(2);

      // Simultaneous rise of buttons 0 and 3 with rr=0: 0 first, 3 five edges later.
      btn_in = 4'b1001;
      step(7);
      chk("sim_lvl0",   {28'h0, lvl}, 32'h1);
      chk("sim_data0",  {24'h0, kb_if.kb_data}, 32'h30);
      step(4);
      chk("sim_lvl3_early", {28'h0, lvl}, 32'h1);
      step(1);
      chk("sim_lvl3",   {28'h0, lvl}, 32'h9);
      chk("sim_head",   {24'h0, kb_if.kb_data}, 32'h30);
      btn_in = 4'b0000;
      step(7);
      chk("sim_rel0",   {28'h0, lvl}, 32'h8);
      step(5);
      chk("sim_rel3",   {28'h0, lvl}, 32'h0);
      ack_pulse();
      chk("sim_pop1",   {24'h0, kb_if.kb_data}, 32'h33);
      ack_pulse();
      chk("sim_empty",  {31'h0, kb_if.kb_ready}, 32'h0);

      // Clean press of button 2: 7 edges to lvl, busy for 4 cycles.
      btn_in = 4'b0100;
      step(2);
      chk("prs_busy_pre", {31'h0, busy}, 32'h0);
      step(1);
      chk("prs_busy",   {31'h0, busy}, 32'h1);
      step(3);
      chk("prs_lvl_early", {28'h0, lvl}, 32'h0);
      chk("prs_busy_end", {31'h0, busy}, 32'h1);
      step(1);
      chk("prs_lvl",    {28'h0, lvl}, 32'h4);
      chk("prs_ready",  {31'h0, kb_if.kb_ready}, 32'h1);
      chk("prs_data",   {24'h0, kb_if.kb_data}, 32'h32);
      chk("prs_busy_off", {31'h0, busy}, 32'h0);

      // Release of button 2: level drops, nothing queued.
      btn_in = 4'b0000;
      step(7);
      chk("rel_lvl",    {28'h0, lvl}, 32'h0);
      chk("rel_data",   {24'h0, kb_if.kb_data}, 32'h32);
      ack_pulse();
      chk("rel_pop",    {31'h0, kb_if.kb_ready}, 32'h0);
      chk("rel_pop_data", {24'h0, kb_if.kb_data}, 32'h0);
      ack_pulse();
      chk("ack_empty",  {31'h0, kb_if.kb_ready}, 32'h0);

      // Bounce on button 1: short busy pulse, no level change, no push.
      btn_in = 4'b0010;
      step(2);
      btn_in = 4'b0000;
      step(1);
      chk("bnc_busy",   {31'h0, busy}, 32'h1);
      step(2);
      chk("bnc_idle",   {31'h0, busy}, 32'h0);
      chk("bnc_lvl",    {28'h0, lvl}, 32'h0);
      chk("bnc_ready",  {31'h0, kb_if.kb_ready}, 32'h0);

      // rr is now 2: buttons 0 and 3 together resolve 3 first.
      btn_in = 4'b1001;
      step(7);
      chk("rr2_lvl",    {28'h0, lvl}, 32'h8);
      chk("rr2_data",   {24'h0, kb_if.kb_data}, 32'h33);
      step(5);
      chk("rr2_lvl_both", {28'h0, lvl}, 32'h9);
      btn_in = 4'b0000;
      step(12);
      chk("rr2_rel",    {28'h0, lvl}, 32'h0);
      ack_pulse();
      chk("rr2_pop",    {24'h0, kb_if.kb_data}, 32'h30);
      ack_pulse();

      // Fill the FIFO, then push-with-pop when full, then a dropped push.
      press_release(0);
      press_release(1);
      press_release(2);
      press_release(3);
      chk("full_head",  {24'h0, kb_if.kb_data}, 32'h30);
      chk("full_ovf",   {31'h0, ovf}, 32'h0);
      btn_in[0] = 1'b1;
      step(6);
      kb_if.kb_ack = 1'b1;
      step(1);
      kb_if.kb_ack = 1'b0;
      chk("pp_lvl",     {28'h0, lvl}, 32'h1);
      chk("pp_ovf",     {31'h0, ovf}, 32'h0);
      chk("pp_head",    {24'h0, kb_if.kb_data}, 32'h31);
      btn_in[0] = 1'b0;
      step(7);
      press_release(1);
      chk("ovf_set",    {31'h0, ovf}, 32'h1);
      chk("ovf_head",   {24'h0, kb_if.kb_data}, 32'h31);
      ack_pulse();
      chk("drain1",     {24'h0, kb_if.kb_data}, 32'h32);
      ack_pulse();
      chk("drain2",     {24'h0, kb_if.kb_data}, 32'h33);
      ack_pulse();
      chk("drain3",     {24'h0, kb_if.kb_data}, 32'h30);
      ack_pulse();
      chk("drain_ready", {31'h0, kb_if.kb_ready}, 32'h0);
      chk("drain_ovf",  {31'h0, ovf}, 32'h1);
      ack_pulse();
      chk("drain_extra", {24'h0, kb_if.kb_data}, 32'h0);

      // Async reset mid-settle with button 1 held, then a fresh debounce.
      btn_in = 4'b0010;
      step(4);
      chk("ar_busy",    {31'h0, busy}, 32'h1);
      reset = 1'b0;
      #1;
      chk("ar_busy0",   {31'h0, busy}, 32'h0);
      chk("ar_lvl0",    {28'h0, lvl}, 32'h0);
      chk("ar_ovf0",    {31'h0, ovf}, 32'h0);
      chk("ar_ready0",  {31'h0, kb_if.kb_ready}, 32'h0);
      step(2);
      reset = 1'b1;
      step(6);
      chk("ar_lvl_early", {28'h0, lvl}, 32'h0);
      step(1);
      chk("ar_lvl",     {28'h0, lvl}, 32'h2);
      chk("ar_ready",   {31'h0, kb_if.kb_ready}, 32'h1);
      chk("ar_data",    {24'h0, kb_if.kb_data}, 32'h31);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
